// File: rtl/scfifo_arb_pkg.sv
// Shared types and helpers for the scfifo_wr_arb round-robin FIFO write arbiter.
package scfifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   localparam int BURST_MAX_DEF = 4;

   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/scfifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      int p;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      p   = 0;
      for (int k = 0; k < NREQ; k++) begin
         p = int'(ptr) + k;
         if (p >= NREQ) p = p - NREQ;
         if (!any && req[p]) begin
            any    = 1'b1;
            gnt[p] = 1'b1;
            idx    = IW'(p);
         end
      end
   end

endmodule

// File: rtl/scfifo_wr_arb.sv
// Round-robin arbiter sharing one ScFifo2 write port among NREQ producers.
// Optional burst lock is compiled in with `define SCFIFO_ARB_BURST_EN.
module scfifo_wr_arb
   import scfifo_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int CW        = 16,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DW-1:0]        req_data,
   output logic [NREQ-1:0]           req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_write,
   output logic [DW-1:0]             fifo_din,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   input  logic                      cnt_clr,
   output logic [NREQ*CW-1:0]        acc_cnt
);

   localparam int IW = clog2_min1(NREQ);

   if (NREQ < 2 || NREQ > 16 || BURST_MAX < 1) begin : g_bad_cfg
      $error("scfifo_wr_arb: unsupported NREQ/BURST_MAX");
   end

   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      last_q, last_d;
   logic [NREQ*CW-1:0] acc_q, acc_d;

   logic [NREQ-1:0]    pick_req;
   logic [IW-1:0]      pick_ptr;
   logic [NREQ-1:0]    gnt;
   logic [IW-1:0]      idx;
   logic               any;
   logic               beat;

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] v);
      return (int'(v) == NREQ - 1) ? '0 : v + IW'(1);
   endfunction

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req  (pick_req),
      .ptr  (pick_ptr),
      .gnt  (gnt),
      .idx  (idx),
      .any  (any)
   );

   // fifo_full and rst gate the handshake combinationally so a full FIFO is never written.
   always_comb begin
      req_ready  = (fifo_full || rst) ? '0 : gnt;
      fifo_write = |(req_valid & req_ready);
      beat       = fifo_write;
      fifo_din   = req_data[int'(idx)*DW +: DW];
      grant_id   = (any && !rst) ? idx : last_q;
      last_d     = any ? idx : last_q;
      acc_cnt    = acc_q;
   end

`ifdef SCFIFO_ARB_BURST_EN
   localparam int BW = clog2_min1(BURST_MAX + 1);

   arb_state_e     state_q, state_d;
   logic [IW-1:0]  lock_q, lock_d;
   logic [BW-1:0]  beats_q, beats_d;

   always_comb begin
      pick_req = (state_q == LOCK) ? (req_valid & (NREQ'(1) << lock_q)) : req_valid;
      pick_ptr = (state_q == LOCK) ? lock_q : ptr_q;
      state_d  = state_q;
      lock_d   = lock_q;
      beats_d  = beats_q;
      ptr_d    = beat ? ptr_inc(idx) : ptr_q;
      case (state_q)
         IDLE: begin
            if (beat && BURST_MAX > 1 && req_valid[idx]) begin
               state_d = LOCK;
               lock_d  = idx;
               beats_d = BW'(1);
            end
         end
         LOCK: begin
            if (!req_valid[lock_q]) begin
               state_d = IDLE;
               beats_d = '0;
               ptr_d   = ptr_inc(lock_q);
            end else if (beat) begin
               beats_d = beats_q + BW'(1);
               if (beats_d == BW'(BURST_MAX)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lock_q  <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         beats_q <= beats_d;
      end
   end
`else
   always_comb begin
      pick_req = req_valid;
      pick_ptr = ptr_q;
      ptr_d    = beat ? ptr_inc(idx) : ptr_q;
   end
`endif

   // Clear wins over a same-cycle increment; counters stick at all-ones.
   always_comb begin
      acc_d = acc_q;
      if (cnt_clr) begin
         acc_d = '0;
      end else if (beat) begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i] && (acc_q[i*CW +: CW] != {CW{1'b1}})) begin
               acc_d[i*CW +: CW] = acc_q[i*CW +: CW] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         last_q <= '0;
         acc_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         last_q <= last_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: doc/scfifo_wr_arb.md
# scfifo_wr_arb

Round-robin write arbiter sharing one `ScFifo2` write port among `NREQ` producers. Each producer has a valid/ready handshake. The arbiter drives the FIFO's `write` and `din` from the single granted producer and never writes while the FIFO reports `full`. Per-requester accepted-word counters support debug and performance checks. The block sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, 2..16
- `DW`, 8 — data width; must match the FIFO `DW`
- `CW`, 16 — width of each accepted-word counter
- `BURST_MAX`, 4 — maximum beats per grant; used only when burst lock is compiled in

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in `NREQ` — requester i holds data
- `req_data` in `NREQ`×`DW` — packed array, one word per requester
- `req_ready` out `NREQ` — one-hot or zero; beat i occurs when `req_valid[i] & req_ready[i]`
- `fifo_full` in 1 — from FIFO `full`
- `fifo_write` out 1 — to FIFO `write`
- `fifo_din` out `DW` — to FIFO `din`
- `grant_id` out `$clog2(NREQ)` — index of the current winner; valid when `fifo_write`=1
- `cnt_clr` in 1 — synchronous clear of all accepted-word counters
- `acc_cnt` out `NREQ`×`CW` — accepted words per requester

## Operation
- Winner: the first requester with `req_valid` set, searching upward from priority pointer `ptr` and wrapping NREQ-1→0.
- `req_ready[w] = ~fifo_full & ~rst` for winner w; all other ready bits are 0.
- Write mux: `fifo_write = |(req_valid & req_ready)`, `fifo_din = req_data[w]`. Both are combinational, so the transfer lands in the FIFO in the same cycle.
- Pointer update happens only on a beat: `ptr <= w+1`, mod `NREQ`.
- No beat while `fifo_full`=1: `ptr` holds and the counters hold.
- Stall: a requester that is not granted keeps `req_valid` and its data stable. The arbiter does not require this, but fairness does.
- Counters: on each beat, `acc_cnt[w]` increments by 1 and saturates at 2^CW−1. `cnt_clr` takes priority over an increment in the same cycle.
- No valid requester: `fifo_write`=0, `req_ready`=0, `grant_id` holds its last value.
- Reset values: `ptr`=0, state IDLE, beat count 0, all `acc_cnt`=0, `grant_id`=0. `req_ready` and `fifo_write` are forced to 0 while `rst`=1.
- Reset mid-burst: the lock drops immediately and the next cycle starts from `ptr`=0.

## Timing
- Zero-cycle latency from `req_valid` to `fifo_write`; one beat per cycle at most.
- `fifo_full` enters the output path combinationally, so a write while the FIFO is full is impossible.
- Fairness: with all requesters valid and the FIFO never full, each requester gets one beat in every `NREQ` consecutive cycles (burst lock off).
- Simultaneous FIFO read and write at full is not supported: `write` is blocked whenever `full`=1, matching the FIFO's guarded write.

## Configuration
- Macro `SCFIFO_ARB_BURST_EN`.
- Defined: two-state FSM, IDLE and LOCK.
  - IDLE→LOCK on a beat by w, when `BURST_MAX`>1 and w still has `req_valid` set. Latch `lock_id`=w and `beats`=1.
  - In LOCK, only `lock_id` can win; `beats` increments per beat.
  - LOCK→IDLE when `beats` reaches `BURST_MAX`, or when `req_valid[lock_id]`=0 in a cycle. On exit, `ptr <= lock_id+1`.
  - `fifo_full` in LOCK holds the state and `beats`; it does not release the lock.
- Undefined: no FSM; arbitration is per-beat, as described in Operation.

## Structure
- Package `scfifo_arb_pkg` contains:
  - `arb_state_e` enum {IDLE, LOCK}
  - function `clog2_min1(n)` for the index width (returns ≥1)
  - localparam default `BURST_MAX`
- Sub-module `rr_pick` is purely combinational.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `gnt`, `idx`, `any`.
  - It is instantiated once in this block.
- Target size: ~200 lines of RTL.

## Test plan
1. All 4 requesters valid, FIFO never full, 8 cycles, burst off → `grant_id` sequence 0,1,2,3,0,1,2,3; each `acc_cnt`=2.
2. Only requester 2 valid, 5 beats, then `fifo_full`=1 for 3 cycles → `fifo_write`=0 and `req_ready`=0 during the stall; `acc_cnt[2]`=5; `ptr`=3.
3. Requesters 1 and 3 valid from reset, `ptr`=0 → first winner 1, then 3, then 1; requesters 0 and 2 always have ready=0.
4. Burst on, `BURST_MAX`=4, requesters 0 and 1 valid continuously → grants 0,0,0,0,1,1,1,1,0…; a full cycle inside a burst adds no beat and keeps the lock.
5. Burst on; requester 0 drops valid after 2 beats while requester 3 is valid → the next beat goes to requester 3 and `ptr` becomes 0 afterwards; `rst` asserted mid-burst → outputs 0, next grant search starts from 0.
6. `CW`=4, requester 1 makes 20 beats → `acc_cnt[1]`=15, saturated; `cnt_clr` asserted together with a beat → `acc_cnt[1]`=0.
